// File: rtl/imem_fetch_ctrl_if.sv
// Instruction-memory port bundle: single-port, synchronous-read RAM with one-cycle
// read latency. The controller drives it as master and the RAM responds as slave.
interface imem_fetch_ctrl_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_en,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_en,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Fetch-side controller for the RV32IM pipeline. It issues sequential instruction
// fetches, absorbs IF/ID stalls with a one-entry skid buffer and flushes on
// redirects. It also hands the memory port to a program loader, which always
// wins over fetch.
module imem_fetch_ctrl #(
    parameter int unsigned ADDR_W   = 10,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                redirect,
    input  logic [31:0]         redirect_pc,
    input  logic                load_req,
    input  logic [ADDR_W-1:0]   load_addr,
    input  logic [31:0]         load_data,
    output logic                load_ack,
    imem_fetch_ctrl_if.master   mem,
    output logic [31:0]         instr_out,
    output logic [31:0]         pc_out,
    output logic                instr_valid
);

    localparam logic [31:0] Nop = 32'h0000_0013;

    typedef enum logic [0:0] {StFetch, StLoad} state_e;

    state_e      state;
    logic [31:0] fetch_pc;
    logic        inflight;
    logic [31:0] inflight_pc;
    logic        skid_valid;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;

    logic        issue;
    logic        load_wr;

    // Redirect targets are word aligned; the low bits are dropped on purpose.
    logic        unused_pc_bits;
    assign unused_pc_bits = ^redirect_pc[1:0];

    // Port arbitration: loader writes in LOAD, otherwise a read of fetch_pc when free.
    always_comb begin
        issue         = !rst && (state == StFetch) && !stall && !redirect && !load_req;
        load_wr       = !rst && (state == StLoad) && load_req;
        mem.mem_en    = issue || load_wr;
        mem.mem_we    = load_wr;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        if (load_wr) begin
            mem.mem_addr  = load_addr;
            mem.mem_wdata = load_data;
        end else if (!rst) begin
            mem.mem_addr  = fetch_pc[ADDR_W+1:2];
        end
        load_ack      = load_wr;
    end

    // Mode FSM, fetch PC, in-flight tracking, skid buffer and IF/ID output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StFetch;
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            skid_valid  <= 1'b0;
            skid_instr  <= Nop;
            skid_pc     <= '0;
            instr_valid <= 1'b0;
            instr_out   <= Nop;
            pc_out      <= '0;
        end else begin
            unique case (state)
                StFetch: begin
                    if (load_req) begin
                        state       <= StLoad;
                        inflight    <= 1'b0;
                        skid_valid  <= 1'b0;
                        instr_valid <= 1'b0;
                    end else if (redirect) begin
                        // Flush everything younger than the branch; the target issues next cycle.
                        inflight    <= 1'b0;
                        skid_valid  <= 1'b0;
                        instr_valid <= 1'b0;
                        fetch_pc    <= {redirect_pc[31:2], 2'b00};
                    end else begin
                        if (inflight) begin
                            if (!instr_valid || !stall) begin
                                instr_valid <= 1'b1;
                                if (skid_valid) begin
                                    // Older skid entry goes out first to keep program order.
                                    instr_out  <= skid_instr;
                                    pc_out     <= skid_pc;
                                    skid_instr <= mem.mem_rdata;
                                    skid_pc    <= inflight_pc;
                                end else begin
                                    instr_out  <= mem.mem_rdata;
                                    pc_out     <= inflight_pc;
                                end
                            end else begin
                                // Decode is holding the output; park the late response.
                                skid_valid <= 1'b1;
                                skid_instr <= mem.mem_rdata;
                                skid_pc    <= inflight_pc;
                            end
                        end else if (!stall) begin
                            if (skid_valid) begin
                                instr_out   <= skid_instr;
                                pc_out      <= skid_pc;
                                skid_valid  <= 1'b0;
                                instr_valid <= 1'b1;
                            end else begin
                                instr_valid <= 1'b0;
                            end
                        end
                        inflight <= issue;
                        if (issue) begin
                            inflight_pc <= fetch_pc;
                            fetch_pc    <= fetch_pc + 32'd4;
                        end
                    end
                end
                StLoad: begin
                    if (!load_req) begin
                        state    <= StFetch;
                        fetch_pc <= RESET_PC;
                    end
                    inflight    <= 1'b0;
                    skid_valid  <= 1'b0;
                    instr_valid <= 1'b0;
                end
                default: state <= StFetch;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: a RAM model on the memory port, directed timing
// checks, then randomized stall/redirect/load traffic. Every instruction accepted
// by decode is checked against a scoreboard fed by a program-order reference model.
module tb_imem_fetch_ctrl;

    localparam int unsigned AW  = 10;
    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stall = 1'b0;
    logic          redirect = 1'b0;
    logic [31:0]   redirect_pc = '0;
    logic          load_req = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [31:0]   load_data = '0;
    logic          load_ack;
    logic [31:0]   instr_out;
    logic [31:0]   pc_out;
    logic          instr_valid;

    imem_fetch_ctrl_if #(.ADDR_W(AW)) bus ();

    imem_fetch_ctrl #(
        .ADDR_W   (AW),
        .RESET_PC (RPC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .load_req    (load_req),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .load_ack    (load_ack),
        .mem         (bus),
        .instr_out   (instr_out),
        .pc_out      (pc_out),
        .instr_valid (instr_valid)
    );

    always #5 clk = ~clk;

    // RAM: one-cycle read latency, writes land on the edge.
    logic [31:0] mem [1024];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= mem[bus.mem_addr];
        end
    end

    int vectors = 0;
    int miscompares = 0;
    int accepts = 0;

    function automatic void check(input string name, input logic [31:0] got,
                                  input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
        end
    endfunction

    // Reference model: expected program-order stream of (pc, instr).
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] refmem [1024];
    logic [31:0] next_pc;
    bit          in_load;

    function automatic void restart(input logic [31:0] pc);
        sb.delete();
        next_pc = pc;
    endfunction

    function automatic void refill();
        exp_t e;
        while (!in_load && sb.size() < 4) begin
            e.pc    = next_pc;
            e.instr = refmem[next_pc[AW+1:2]];
            sb.push_back(e);
            next_pc = next_pc + 32'd4;
        end
    endfunction

    // Applies the effect of the inputs held during the cycle that just ended.
    function automatic void model_edge();
        if (rst) begin
            in_load = 1'b0;
            restart(RPC);
        end else if (!in_load) begin
            if (load_req) begin
                in_load = 1'b1;
                sb.delete();
            end else if (redirect) begin
                restart({redirect_pc[31:2], 2'b00});
            end
        end else begin
            if (load_req) refmem[load_addr] = load_data;
            else begin
                in_load = 1'b0;
                restart(RPC);
            end
        end
        refill();
    endfunction

    // Monitor: every instruction taken by decode must be the next expected one.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && instr_valid && !stall) begin
            accepts++;
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL sb_unexpected at %0t: got pc %h, expected no output", $time, pc_out);
            end else begin
                e = sb.pop_front();
                check("sb_pc", pc_out, e.pc);
                check("sb_instr", instr_out, e.instr);
            end
        end
    end

    task automatic cyc(input logic r, input logic s, input logic rd, input logic [31:0] rpc,
                       input logic lr, input logic [AW-1:0] la, input logic [31:0] ld);
        @(posedge clk);
        model_edge();
        #1;
        rst = r; stall = s; redirect = rd; redirect_pc = rpc;
        load_req = lr; load_addr = la; load_data = ld;
    endtask

    task automatic go(input logic s);
        cyc(1'b0, s, 1'b0, 32'h0, 1'b0, '0, 32'h0);
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic          s, rd, lr;
        logic [31:0]   rpc, v;

        for (int i = 0; i < 1024; i++) begin
            v = $urandom;
            mem[i] = v;
            refmem[i] = v;
        end
        mem[0] = 32'h0000_0A13; refmem[0] = 32'h0000_0A13;
        mem[1] = 32'h0000_0B13; refmem[1] = 32'h0000_0B13;
        mem[2] = 32'h0000_0C13; refmem[2] = 32'h0000_0C13;
        mem[3] = 32'h0000_0D13; refmem[3] = 32'h0000_0D13;
        in_load = 1'b0;
        restart(RPC);
        refill();

        // Reset masks a loader request and leaves the port idle.
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 10'd5, 32'hDEAD_BEEF);
        sample();
        check("rst_load_ack", 32'(load_ack), 32'd0);
        check("rst_mem_en", 32'(bus.mem_en), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, '0, 32'h0);
        sample();
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr_out, NOP);
        check("rst_pc", pc_out, 32'd0);

        // Cycle 0..3: first fetch and streaming.
        go(1'b0); sample();
        check("c0_mem_en", 32'(bus.mem_en), 32'd1);
        check("c0_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("c0_valid", 32'(instr_valid), 32'd0);
        go(1'b0); sample();
        check("c1_valid", 32'(instr_valid), 32'd0);
        go(1'b0); sample();
        check("c2_valid", 32'(instr_valid), 32'd1);
        check("c2_pc", pc_out, 32'd0);
        check("c2_instr", instr_out, 32'h0000_0A13);
        go(1'b0); sample();
        check("c3_pc", pc_out, 32'd4);
        check("c3_instr", instr_out, 32'h0000_0B13);

        // Cycles 4..6 stalled: output frozen on pc 8, port idle.
        for (int i = 0; i < 3; i++) begin
            go(1'b1); sample();
            check("stall_valid", 32'(instr_valid), 32'd1);
            check("stall_pc", pc_out, 32'd8);
            check("stall_mem_en", 32'(bus.mem_en), 32'd0);
        end
        go(1'b0); sample();
        check("rel_pc", pc_out, 32'd8);
        check("rel_mem_en", 32'(bus.mem_en), 32'd1);
        check("rel_mem_addr", 32'(bus.mem_addr), 32'd4);
        go(1'b0); sample();
        check("rel1_valid", 32'(instr_valid), 32'd1);
        check("rel1_pc", pc_out, 32'd12);
        check("rel1_instr", instr_out, 32'h0000_0D13);
        go(1'b0); sample();
        check("rel2_valid", 32'(instr_valid), 32'd1);
        check("rel2_pc", pc_out, 32'd16);

        // Redirect to 0x42.
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_0042, 1'b0, '0, 32'h0);
        go(1'b0); sample();
        check("rd1_valid", 32'(instr_valid), 32'd0);
        check("rd1_mem_en", 32'(bus.mem_en), 32'd1);
        check("rd1_mem_addr", 32'(bus.mem_addr), 32'h10);
        go(1'b0); sample();
        check("rd2_valid", 32'(instr_valid), 32'd0);
        go(1'b0); sample();
        check("rd3_valid", 32'(instr_valid), 32'd1);
        check("rd3_pc", pc_out, 32'h40);

        // Redirect under stall: flush now, issue only after stall drops.
        cyc(1'b0, 1'b1, 1'b1, 32'h0000_0100, 1'b0, '0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            go(1'b1); sample();
            check("rs_valid", 32'(instr_valid), 32'd0);
            check("rs_mem_en", 32'(bus.mem_en), 32'd0);
        end
        go(1'b0); sample();
        check("rs_issue_en", 32'(bus.mem_en), 32'd1);
        check("rs_issue_addr", 32'(bus.mem_addr), 32'h40);
        go(1'b0); sample();
        check("rs_gap_valid", 32'(instr_valid), 32'd0);
        go(1'b0); sample();
        check("rs_pc", pc_out, 32'h100);

        // Loader session: entry cycle, three writes, exit, restart at RESET_PC.
        go(1'b0); go(1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 10'd5, 32'h11); sample();
        check("ld_entry_en", 32'(bus.mem_en), 32'd0);
        check("ld_entry_ack", 32'(load_ack), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, AW'(5 + i), 32'(8'h11 * (i + 1))); sample();
            check("ld_ack", 32'(load_ack), 32'd1);
            check("ld_we", 32'(bus.mem_we), 32'd1);
            check("ld_addr", 32'(bus.mem_addr), 32'(5 + i));
            check("ld_wdata", bus.mem_wdata, 32'(8'h11 * (i + 1)));
            check("ld_valid", 32'(instr_valid), 32'd0);
        end
        go(1'b0); sample();
        check("ld_exit_en", 32'(bus.mem_en), 32'd0);
        check("ld_exit_valid", 32'(instr_valid), 32'd0);
        go(1'b0); sample();
        check("ld_restart_en", 32'(bus.mem_en), 32'd1);
        check("ld_restart_addr", 32'(bus.mem_addr), 32'd0);
        go(1'b0); go(1'b0); sample();
        check("ld_restart_pc", pc_out, RPC);
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_0014, 1'b0, '0, 32'h0);
        go(1'b0); go(1'b0); go(1'b0); sample();
        check("ld_readback_pc", pc_out, 32'h14);
        check("ld_readback", instr_out, 32'h11);

        // Address wrap at the top of memory.
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_0FFC, 1'b0, '0, 32'h0);
        go(1'b0); sample();
        check("wrap_addr_top", 32'(bus.mem_addr), 32'd1023);
        go(1'b0); sample();
        check("wrap_addr_zero", 32'(bus.mem_addr), 32'd0);
        go(1'b0); sample();
        check("wrap_pc_top", pc_out, 32'h0FFC);
        go(1'b0); sample();
        check("wrap_pc_next", pc_out, 32'h1000);

        // Reset in the middle of a load session.
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 10'd9, 32'h99);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 10'd9, 32'h99); sample();
        check("rl_ack", 32'(load_ack), 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 10'd10, 32'hAA); sample();
        check("rl_rst_ack", 32'(load_ack), 32'd0);
        check("rl_rst_we", 32'(bus.mem_we), 32'd0);
        go(1'b0); sample();
        check("rl_issue_en", 32'(bus.mem_en), 32'd1);
        check("rl_issue_addr", 32'(bus.mem_addr), 32'd0);
        go(1'b0); go(1'b0); sample();
        check("rl_valid", 32'(instr_valid), 32'd1);
        check("rl_pc", pc_out, RPC);

        // Randomized traffic; the monitor does the checking.
        for (int i = 0; i < 3000; i++) begin
            if (in_load) lr = ($urandom_range(0, 3) != 0);
            else         lr = ($urandom_range(0, 49) == 0);
            s  = ($urandom_range(0, 9) < 3);
            rd = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 1) == 0) rpc = 32'($urandom_range(0, 255));
            else                          rpc = $urandom;
            cyc(1'b0, s, rd, rpc, lr, AW'($urandom_range(0, 63)), $urandom);
        end
        for (int i = 0; i < 8; i++) go(1'b0);
        sample();
        check("accept_progress", 32'(accepts > 500), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
